pixel_result_uart_tx: RTL and testbench
=======================================

// Module: pixel_result_uart_tx
// PURPOSE
//  UART transmit side of the host link. Reports each computed Mandelbrot pixel back to the host.
//  Taps the engine's framebuffer write strobe (px/py/colour/we) and queues each write in a small FIFO.
//  Sends each queued write as a 3-byte 8N1 packet, so the host can mirror or verify the rendered image.
//  Clocked on the 24 MHz system clock, beside the command receiver.
// PARAMETERS
//  CLK_HZ      24000000  system clock frequency (Hz)
//  BAUD        115200    line rate; DIV = CLK_HZ/BAUD (integer divide, DIV >= 2)
//  FIFO_AW     4         FIFO address width; depth DEPTH = 2**FIFO_AW entries of 20 bits
// PORTS
//  clk         in   1    system clock
//  rst         in   1    synchronous, active-high reset
//  pix_x       in   9    pixel X of the write being reported
//  pix_y       in   8    pixel Y of the write being reported
//  pix_d       in   3    pixel colour code (0 = in-set/black, 1..7 = escape colour)
//  pix_we      in   1    1-cycle write strobe; sampled every clk
//  ovf_clr     in   1    clears the sticky overflow flag
//  txd         out  1    UART serial out; idle high
//  tx_busy     out  1    1 while a packet is being shifted out or the FIFO is non-empty
//  overflow    out  1    sticky; set when a pix_we is dropped because the FIFO is full
//  fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: txd=1, tx_busy=0, overflow=0, fifo_level=0. FIFO is flushed; FSM goes to IDLE; baud counter = 0.
//   Reset during a byte aborts that byte. txd is 1 after the reset edge and no partial packet is resumed.
//  FIFO push:
//   - Edge with pix_we=1 and fifo_level<DEPTH stores {pix_x,pix_y,pix_d}.
//   - Edge with pix_we=1 and fifo_level==DEPTH drops the write and sets overflow. Fullness is judged on the
//     registered level, so the write is dropped even if a pop happens on the same edge.
//  FIFO pop: only in IDLE with level>0. Push and pop on the same edge leave the level unchanged.
//  Overflow flag: if ovf_clr and an overflow event occur on the same edge, the set wins.
//  Packet format (only byte0 has MSB set, so the host can resync):
//   byte0 = {1'b1, x[8:7], y[7], 1'b0, d[2:0]}   byte1 = {1'b0, x[6:0]}   byte2 = {1'b0, y[6:0]}
//  Line format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1; each bit lasts exactly DIV clocks.
//  FSM states and transitions:
//   IDLE -> START: on edge E, pop the entry, latch it, load byte0, drive txd=0.
//   START -> DATA after DIV clocks.
//   DATA: bit k held DIV clocks, k=0..7. DATA -> STOP after bit 7.
//   STOP: txd=1 for DIV clocks. Then if byte_idx<2, increment byte_idx and go to START with the next byte,
//     with no idle gap. Otherwise go to IDLE.
//  Latency: pix_we sampled at edge N into an empty FIFO while IDLE -> txd falls after edge N+1.
//  Packet length = 30*DIV clocks. Back-to-back packets: IDLE lasts exactly 1 clock between packets.
//  tx_busy = (state!=IDLE) | (fifo_level!=0).
//  FIFO pointers wrap modulo DEPTH. Level is a separate FIFO_AW+1-bit counter, so full and empty are unambiguous.
// TESTING (sim with CLK_HZ=1000, BAUD=100 -> DIV=10, FIFO_AW=4 -> DEPTH=16)
//  1 Reset: assert rst 3 clk -> txd=1, tx_busy=0, overflow=0, fifo_level=0; txd stays 1 for 500 clk with no pix_we.
//  2 Single pixel x=0x105, y=0x81, d=5 -> txd low 1 clk after the strobe edge; bytes 0xD5,0x05,0x01;
//    each bit 10 clk; packet 300 clk; tx_busy falls at the end of the last stop bit.
//  3 Burst of 18 consecutive pix_we (x=i, y=i, d=i%8) while idle -> 17 accepted, fifo_level peaks at 16,
//    overflow=1; exactly 17 packets received in order i=0..16; the 18th write is absent.
//  4 Overflow with ovf_clr=1 on the dropping edge -> overflow=1; a later ovf_clr with no drop -> overflow=0 next edge.
//  5 rst asserted at data bit 4 of byte1 with 3 entries queued -> txd=1, fifo_level=0 next edge;
//    no further start bit after rst release.
//  6 Push on the same edge as a pop at fifo_level=16 -> push dropped, overflow set, fifo_level=15.

Source files
------------

// File: rtl/pixel_result_uart_tx.sv
// Host-link UART transmitter: queues framebuffer writes in a FIFO and sends each
// one as a 3-byte 8N1 packet whose first byte alone carries the MSB resync marker.
module pixel_result_uart_tx #(
  parameter int CLK_HZ  = 24000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       pix_x,
  input  logic [7:0]       pix_y,
  input  logic [2:0]       pix_d,
  input  logic             pix_we,
  input  logic             ovf_clr,
  output logic             txd,
  output logic             tx_busy,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_level
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [19:0]        pkt_q, pkt_d;
  logic               txd_q, txd_d;
  logic [7:0]         nxt_byte;
  logic               baud_tick;

  logic [19:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q;
  logic               fifo_full, fifo_empty, push, drop, pop;

  // Packet entry layout is {x[8:0], y[7:0], d[2:0]}.
  function automatic logic [7:0] pkt_byte(input logic [19:0] p, input logic [1:0] idx);
    case (idx)
      2'd0:    return {1'b1, p[19:18], p[10], 1'b0, p[2:0]};
      2'd1:    return {1'b0, p[17:11]};
      default: return {1'b0, p[9:3]};
    endcase
  endfunction

  // Fullness uses the registered level, so a same-edge pop never rescues a push.
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign push       = pix_we && !fifo_full;
  assign drop       = pix_we && fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pix_x, pix_y, pix_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Line FSM: txd is registered from the next-state values to keep the line glitch-free.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pkt_d     = pkt_q;
    baud_tick = (cnt_q == CNT_LAST);
    if (state_q != S_IDLE) cnt_d = baud_tick ? '0 : cnt_q + CNT_ONE;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          pkt_d   = mem_q[rd_ptr_q];
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (byte_q < 2'd2) begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    nxt_byte = pkt_byte(pkt_d, byte_d);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = nxt_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    pkt_q <= pkt_d;
  end

  assign txd        = txd_q;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_pixel_result_uart_tx.sv
// Bench for pixel_result_uart_tx: directed scenarios plus random pixel bursts, decoded by a
// behavioural UART receiver and compared with byte queues built from the packet format.
module tb_pixel_result_uart_tx;
  localparam int CLK_HZ  = 1000;
  localparam int BAUD    = 100;
  localparam int FIFO_AW = 4;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int PKT     = 30 * DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [8:0]       pix_x = '0;
  logic [7:0]       pix_y = '0;
  logic [2:0]       pix_d = '0;
  logic             pix_we = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             txd, tx_busy, overflow;
  logic [FIFO_AW:0] fifo_level;

  pixel_result_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_d(pix_d),
    .pix_we(pix_we), .ovf_clr(ovf_clr), .txd(txd), .tx_busy(tx_busy),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic       rst_at_edge = 1'b1;
  logic [7:0] rx_byte_q[$];
  int         rx_start_q[$];
  int         rx_ferr = 0;
  logic [7:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_at_edge = rst;
  end

  // Line receiver: frame found on a falling edge, each bit sampled mid-cell.
  initial begin : rx
    logic       prev, on;
    int         t0, off, idx;
    logic [7:0] sh;
    prev = 1'b1; on = 1'b0; t0 = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) on = 1'b0;
      else if (!on) begin
        if (prev === 1'b1 && txd === 1'b0) begin
          on = 1'b1; t0 = cyc; sh = '0;
          rx_start_q.push_back(cyc);
        end
      end else begin
        off = cyc - t0;
        if (off % DIV == DIV / 2) begin
          idx = off / DIV;
          if (idx == 0) begin
            if (txd !== 1'b0) rx_ferr++;
          end else if (idx <= 8) sh[idx-1] = txd;
          else begin
            if (txd !== 1'b1) rx_ferr++;
            rx_byte_q.push_back(sh);
            on = 1'b0;
          end
        end
      end
      prev = txd;
    end
  end

  function automatic logic [7:0] model_byte(input logic [8:0] x, input logic [7:0] y,
                                            input logic [2:0] d, input int k);
    case (k)
      0:       return {1'b1, x[8:7], y[7], 1'b0, d};
      1:       return {1'b0, x[6:0]};
      default: return {1'b0, y[6:0]};
    endcase
  endfunction

  task automatic add_pkt(input logic [8:0] x, input logic [7:0] y, input logic [2:0] d,
                         input int nbytes);
    for (int k = 0; k < nbytes; k++) exp_q.push_back(model_byte(x, y, d, k));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin step(); n++; end
    chk(tag, {31'd0, tx_busy}, 32'd0);
    repeat (3) step();
  endtask

  task automatic check_bytes(input string tag);
    int n;
    chk({tag, "_count"}, rx_byte_q.size(), exp_q.size());
    n = (rx_byte_q.size() < exp_q.size()) ? rx_byte_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_byte_q[i]}, {24'd0, exp_q[i]});
    rx_byte_q.delete();
    exp_q.delete();
    rx_start_q.delete();
  endtask

  task automatic wait_cyc(input string tag, input int t);
    while (cyc < t) step();
    chk(tag, cyc, t);
  endtask

  initial begin
    int c, s, lows, nb;
    logic [8:0] rx_x;
    logic [7:0] ry;
    logic [2:0] rd;

    // Reset behaviour and quiet line
    repeat (3) step();
    chk("rst_txd", {31'd0, txd}, 32'd1);
    rst = 1'b0;
    step();
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    lows = 0;
    for (int i = 0; i < 500; i++) begin step(); if (txd !== 1'b1) lows++; end
    chk("idle_txd_low_count", lows, 0);

    // Single pixel: latency, byte content, bit timing, packet length
    rx_start_q.delete();
    c = cyc;
    pix_x = 9'h105; pix_y = 8'h81; pix_d = 3'd5; pix_we = 1'b1;
    add_pkt(9'h105, 8'h81, 3'd5, 3);
    step();
    pix_we = 1'b0;
    chk("single_txd_before", {31'd0, txd}, 32'd1);
    step();
    chk("single_txd_fall", {31'd0, txd}, 32'd0);
    s = c + 2;
    wait_cyc("single_align_end", s + PKT - 1);
    chk("single_busy_last", {31'd0, tx_busy}, 32'd1);
    step();
    chk("single_busy_fall", {31'd0, tx_busy}, 32'd0);
    repeat (3) step();
    chk("single_starts", rx_start_q.size(), 3);
    for (int k = 0; k < rx_start_q.size(); k++)
      chk($sformatf("single_start%0d", k), rx_start_q[k], s + 10 * DIV * k);
    check_bytes("single");

    // Burst of 18 writes while idle: 17 accepted, last dropped
    for (int i = 0; i < 18; i++) begin
      pix_x = 9'(i); pix_y = 8'(i); pix_d = 3'(i % 8); pix_we = 1'b1;
      if (i < 17) add_pkt(9'(i), 8'(i), 3'(i % 8), 3);
      step();
      if (i == 16) chk("burst_peak_level", {27'd0, fifo_level}, 32'd16);
    end
    pix_we = 1'b0;
    chk("burst_level_after_drop", {27'd0, fifo_level}, 32'd16);
    chk("burst_ovf", {31'd0, overflow}, 32'd1);
    wait_idle("burst_drain", 17 * (PKT + 1) + 50);
    check_bytes("burst");

    // Overflow set-wins with ovf_clr, then a plain clear
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clear1", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 18; i++) begin
      pix_x = 9'(9'h100 + i); pix_y = 8'(8'h40 + i); pix_d = 3'(7 - (i % 8)); pix_we = 1'b1;
      ovf_clr = (i == 17);
      if (i < 17) add_pkt(9'(9'h100 + i), 8'(8'h40 + i), 3'(7 - (i % 8)), 3);
      step();
    end
    pix_we = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clear2", {31'd0, overflow}, 32'd0);

    // Push on the pop edge with a full FIFO
    chk("pushpop_have_start", {31'd0, rx_start_q.size() > 0}, 32'd1);
    s = (rx_start_q.size() > 0) ? rx_start_q[0] : cyc;
    wait_cyc("pushpop_align", s + PKT);
    chk("pushpop_level_before", {27'd0, fifo_level}, 32'd16);
    pix_x = 9'h1FF; pix_y = 8'hFF; pix_d = 3'd7; pix_we = 1'b1;
    step();
    pix_we = 1'b0;
    chk("pushpop_level_after", {27'd0, fifo_level}, 32'd15);
    chk("pushpop_ovf", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    wait_idle("pushpop_drain", 17 * (PKT + 1) + 50);
    check_bytes("ovf_pushpop");

    // Reset in the middle of byte1 data bit 4 with 3 entries queued
    for (int i = 0; i < 4; i++) begin
      pix_x = 9'(9'h0AA + 3 * i); pix_y = 8'(8'hC3 - i); pix_d = 3'(i + 1); pix_we = 1'b1;
      if (i == 0) add_pkt(9'h0AA, 8'hC3, 3'd1, 1);
      step();
    end
    pix_we = 1'b0;
    chk("rstmid_level", {27'd0, fifo_level}, 32'd3);
    s = (rx_start_q.size() > 0) ? rx_start_q[0] : cyc;
    wait_cyc("rstmid_align", s + 10 * DIV + 5 * DIV + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_txd", {31'd0, txd}, 32'd1);
    chk("rstmid_level0", {27'd0, fifo_level}, 32'd0);
    chk("rstmid_busy", {31'd0, tx_busy}, 32'd0);
    lows = 0;
    for (int i = 0; i < 400; i++) begin step(); if (txd !== 1'b1) lows++; end
    chk("rstmid_no_restart", lows, 0);
    chk("rstmid_starts", rx_start_q.size(), 2);
    check_bytes("rstmid");

    // Random bursts that never exceed the FIFO depth
    for (int r = 0; r < 5; r++) begin
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        rx_x = 9'($urandom_range(0, 511));
        ry   = 8'($urandom_range(0, 255));
        rd   = 3'($urandom_range(0, 7));
        pix_x = rx_x; pix_y = ry; pix_d = rd; pix_we = 1'b1;
        add_pkt(rx_x, ry, rd, 3);
        step();
        pix_we = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
      wait_idle($sformatf("rand%0d_drain", r), nb * (PKT + 1) + 100);
      chk($sformatf("rand%0d_level", r), {27'd0, fifo_level}, 32'd0);
      chk($sformatf("rand%0d_ovf", r), {31'd0, overflow}, 32'd0);
    end
    check_bytes("rand");
    chk("framing_errors", rx_ferr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
